// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: PC-select codes,
// interrupt-entry state type and per-buffer flush bit positions.
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_IVT  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH,
    ST_VECTOR
  } int_state_t;

  localparam int FL_IFID  = 0;
  localparam int FL_IDEX  = 1;
  localparam int FL_EXMEM = 2;
  localparam int FL_MEMWB = 3;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Priority forwarding match for one execute operand: nearest writing stage wins,
// 0 selects the register file.
module pipe_fwd_sel #(
  parameter  int FWD_STAGES = 2,
  parameter  int REG_AW     = 3,
  localparam int SW         = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]        fwd_wb,
  output logic [SW-1:0]                sel
);

  // Scan far-to-near so the nearest matching stage is the last assignment.
  always_comb begin
    sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (fwd_wb[k] && (fwd_rd[k*REG_AW +: REG_AW] == rs)) sel = SW'(k + 1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stall, branch flush, forwarding select and interrupt entry.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the saturating performance counters.
//
// state     | meaning
// ST_IDLE   | normal hazard handling; int_req or pending starts entry
// ST_DRAIN  | hold PC, bubble IF/ID while older instructions retire
// ST_PUSH   | memory stage pushes the return PC
// ST_VECTOR | fetch from IVT, acknowledge the interrupt
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter  int NSTAGES    = 5,
  parameter  int REG_AW     = 3,
  parameter  int FWD_STAGES = 2,
  localparam int SW         = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [REG_AW-1:0]            id_rs1,
  input  logic [REG_AW-1:0]            id_rs2,
  input  logic [REG_AW-1:0]            ex_rd,
  input  logic                         ex_wb,
  input  logic                         ex_mem_read,
  input  logic [REG_AW-1:0]            ex_rs1,
  input  logic [REG_AW-1:0]            ex_rs2,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]        fwd_wb,
  input  logic                         br_taken,
  input  logic                         int_req,
  output logic [SW-1:0]                fwd_sel1,
  output logic [SW-1:0]                fwd_sel2,
  output logic                         hold_pc,
  output logic                         hold_ifid,
  output logic [NSTAGES-2:0]           flush,
  output logic [1:0]                   pc_sel,
  output logic                         push_pc,
  output logic                         int_ack,
  output logic                         int_busy,
  output logic [15:0]                  cnt_stall,
  output logic [15:0]                  cnt_flush,
  output logic [15:0]                  cnt_int
);

  localparam int CW = $clog2(NSTAGES + 1);

  int_state_t    state, state_nx;
  logic [CW-1:0] drain_cnt, drain_cnt_nx;
  logic          pending, pending_nx;
  logic          load_use;
  logic          stall_evt, br_evt, int_done;
  logic [SW-1:0] sel1_raw, sel2_raw;

  pipe_fwd_sel #(.FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW)) u_fwd1 (
    .rs(ex_rs1), .fwd_rd(fwd_rd), .fwd_wb(fwd_wb), .sel(sel1_raw)
  );

  pipe_fwd_sel #(.FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW)) u_fwd2 (
    .rs(ex_rs2), .fwd_rd(fwd_rd), .fwd_wb(fwd_wb), .sel(sel2_raw)
  );

  assign fwd_sel1 = rst ? '0 : sel1_raw;
  assign fwd_sel2 = rst ? '0 : sel2_raw;
  assign int_busy = (state != ST_IDLE);

  assign load_use = ex_mem_read && ex_wb && id_valid &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      pending   <= pending_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    pending_nx   = pending;
    hold_pc      = 1'b0;
    hold_ifid    = 1'b0;
    flush        = '0;
    pc_sel       = PC_SEQ;
    push_pc      = 1'b0;
    int_ack      = 1'b0;
    stall_evt    = 1'b0;
    br_evt       = 1'b0;
    int_done     = 1'b0;
    if (rst) begin
      flush = '1;
    end else begin
      if (state != ST_IDLE && int_req) pending_nx = 1'b1;
      case (state)
        ST_IDLE: begin
          pending_nx = 1'b0;
          if (int_req || pending) begin
            state_nx     = ST_DRAIN;
            drain_cnt_nx = CW'(NSTAGES - 2);
          end
          if (br_taken) begin
            pc_sel         = PC_BR;
            flush[FL_IFID] = 1'b1;
            flush[FL_IDEX] = 1'b1;
            br_evt         = 1'b1;
          end else if (load_use) begin
            hold_pc        = 1'b1;
            hold_ifid      = 1'b1;
            pc_sel         = PC_HOLD;
            flush[FL_IDEX] = 1'b1;
            stall_evt      = 1'b1;
          end
        end
        ST_DRAIN: begin
          hold_pc        = 1'b1;
          flush[FL_IFID] = 1'b1;
          pc_sel         = PC_HOLD;
          // A late branch redirects the PC so the pushed return address is its target.
          if (br_taken) begin
            pc_sel         = PC_BR;
            flush[FL_IDEX] = 1'b1;
            br_evt         = 1'b1;
          end
          if (drain_cnt <= CW'(1)) begin
            state_nx     = ST_PUSH;
            drain_cnt_nx = '0;
          end else begin
            drain_cnt_nx = drain_cnt - CW'(1);
          end
        end
        ST_PUSH: begin
          push_pc        = 1'b1;
          hold_pc        = 1'b1;
          flush[FL_IFID] = 1'b1;
          pc_sel         = PC_HOLD;
          state_nx       = ST_VECTOR;
        end
        ST_VECTOR: begin
          pc_sel         = PC_IVT;
          int_ack        = 1'b1;
          flush[FL_IFID] = 1'b1;
          int_done       = 1'b1;
          state_nx       = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stall_q, flush_q, int_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      int_q   <= '0;
    end else begin
      if (stall_evt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (br_evt    && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
      if (int_done  && int_q   != 16'hFFFF) int_q   <= int_q + 16'd1;
    end
  end

  assign cnt_stall = stall_q;
  assign cnt_flush = flush_q;
  assign cnt_int   = int_q;
`else
  logic perf_unused;
  assign perf_unused = ^{stall_evt, br_evt, int_done};
  assign cnt_stall   = '0;
  assign cnt_flush   = '0;
  assign cnt_int     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with the default NSTAGES=5, REG_AW=3, FWD_STAGES=2.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [2:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2;
  logic       ex_wb, ex_mem_read, br_taken, int_req;
  logic [5:0] fwd_rd;
  logic [1:0] fwd_wb;
  logic [1:0] fwd_sel1, fwd_sel2, pc_sel;
  logic       hold_pc, hold_ifid, push_pc, int_ack, int_busy;
  logic [3:0] flush;
  logic [15:0] cnt_stall, cnt_flush, cnt_int;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .fwd_rd(fwd_rd), .fwd_wb(fwd_wb),
    .br_taken(br_taken), .int_req(int_req),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .flush(flush),
    .pc_sel(pc_sel), .push_pc(push_pc), .int_ack(int_ack), .int_busy(int_busy),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_int(cnt_int)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_wb = 0; ex_mem_read = 0; br_taken = 0; int_req = 0;
    fwd_rd = 0; fwd_wb = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_wb = 1; ex_rd = 3'd5;
    id_valid = 1; id_rs2 = 3'd5; id_rs2_used = 1; id_rs1 = 3'd1; id_rs1_used = 1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    ex_rs1 = 3'd3; fwd_rd = {3'd3, 3'd3}; fwd_wb = 2'b11;
    set_load_use();
    @(negedge clk);
    chk("rst_flush", flush, 4'hF);
    chk("rst_hold_pc", hold_pc, 0);
    chk("rst_hold_ifid", hold_ifid, 0);
    chk("rst_pc_sel", pc_sel, 2'b00);
    chk("rst_push", push_pc, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_fwd1", fwd_sel1, 0);

    next_cycle(); rst = 0; clear_inputs();
    @(negedge clk);
    chk("idle_busy", int_busy, 0);
    chk("idle_flush", flush, 0);
    chk("rst_cnt_stall", cnt_stall, 0);
    chk("rst_cnt_int", cnt_int, 0);

    // Forwarding priority
    ex_rs1 = 3'd3; fwd_rd = {3'd3, 3'd3}; fwd_wb = 2'b11; #1;
    chk("fwd1_near", fwd_sel1, 1);
    fwd_wb = 2'b10; #1;
    chk("fwd1_far", fwd_sel1, 2);
    ex_rs1 = 3'd4; #1;
    chk("fwd1_none", fwd_sel1, 0);
    ex_rs2 = 3'd6; fwd_rd = {3'd6, 3'd2}; fwd_wb = 2'b11; #1;
    chk("fwd2_far_only", fwd_sel2, 2);
    ex_rs1 = 3'd0; fwd_rd = {3'd0, 3'd0}; fwd_wb = 2'b01; #1;
    chk("fwd1_r0", fwd_sel1, 1);
    fwd_wb = 2'b00; #1;
    chk("fwd1_wb_off", fwd_sel1, 0);

    // Three load-use stall cycles
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_load_use();
      @(negedge clk);
      chk("lu_hold_pc", hold_pc, 1);
      chk("lu_hold_ifid", hold_ifid, 1);
      chk("lu_flush", flush, 4'b0010);
      chk("lu_pc_sel", pc_sel, 2'b11);
    end
    next_cycle(); br_taken = 1;
    @(negedge clk);
    chk("br_over_lu_flush", flush, 4'b0011);
    chk("br_over_lu_pc_sel", pc_sel, 2'b01);
    chk("br_over_lu_hold", hold_pc, 0);
    next_cycle(); br_taken = 0; id_rs2_used = 0;
    @(negedge clk);
    chk("lu_unused_hold", hold_pc, 0);
    next_cycle(); id_rs2_used = 1; ex_wb = 0;
    @(negedge clk);
    chk("lu_nowb_hold", hold_ifid, 0);
    next_cycle(); clear_inputs(); br_taken = 1;
    @(negedge clk);
    chk("br_flush", flush, 4'b0011);
    chk("br_pc_sel", pc_sel, 2'b01);

    // Interrupt entry: request on cycle 1, vector on cycle 6
    next_cycle(); clear_inputs(); int_req = 1;
    @(negedge clk);
    chk("int_c1_busy", int_busy, 0);
    next_cycle(); int_req = 0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("drain_busy", int_busy, 1);
      chk("drain_hold", hold_pc, 1);
      chk("drain_flush", flush, 4'b0001);
      chk("drain_push", push_pc, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("push_push", push_pc, 1);
    chk("push_hold", hold_pc, 1);
    next_cycle();
    @(negedge clk);
    chk("vec_pc_sel", pc_sel, 2'b10);
    chk("vec_ack", int_ack, 1);
    chk("vec_flush", flush, 4'b0001);
    next_cycle();
    @(negedge clk);
    chk("post_busy", int_busy, 0);
    chk("post_ack", int_ack, 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("cnt_stall", cnt_stall, 3);
    chk("cnt_flush", cnt_flush, 2);
    chk("cnt_int", cnt_int, 1);
`else
    chk("cnt_stall_off", cnt_stall, 0);
    chk("cnt_flush_off", cnt_flush, 0);
    chk("cnt_int_off", cnt_int, 0);
`endif

    // Second entry with masking, branch in DRAIN and a request during PUSH
    next_cycle(); int_req = 1;
    next_cycle(); int_req = 0;
    @(negedge clk);
    chk("s2_drain1", int_busy, 1);
    next_cycle(); set_load_use();
    @(negedge clk);
    chk("s2_lu_masked_ifid", hold_ifid, 0);
    chk("s2_lu_masked_flush", flush, 4'b0001);
    next_cycle(); clear_inputs(); br_taken = 1;
    @(negedge clk);
    chk("s2_drain_br_pc_sel", pc_sel, 2'b01);
    chk("s2_drain_br_flush", flush, 4'b0011);
    chk("s2_drain_br_hold", hold_pc, 1);
    next_cycle(); br_taken = 0; int_req = 1;
    @(negedge clk);
    chk("s2_push", push_pc, 1);
    next_cycle(); int_req = 0;
    @(negedge clk);
    chk("s2_vec_ack", int_ack, 1);
    next_cycle();
    @(negedge clk);
    chk("s3_idle_pending", int_busy, 0);
    next_cycle();
    @(negedge clk);
    chk("s3_drain", int_busy, 1);
    chk("s3_drain_push", push_pc, 0);
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    chk("s3_push", push_pc, 1);
    next_cycle();
    @(negedge clk);
    chk("s3_vec_ack", int_ack, 1);
    chk("s3_vec_pc_sel", pc_sel, 2'b10);
    next_cycle();
    @(negedge clk);
    chk("s3_done_busy", int_busy, 0);

    // Reset during DRAIN aborts the sequence
    next_cycle(); int_req = 1;
    next_cycle(); int_req = 0;
    next_cycle(); rst = 1;
    @(negedge clk);
    chk("rst_drain_flush", flush, 4'hF);
    chk("rst_drain_push", push_pc, 0);
    chk("rst_drain_hold", hold_pc, 0);
    next_cycle(); rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_busy", int_busy, 0);
      chk("abort_ack", int_ack, 0);
      chk("abort_push", push_pc, 0);
      next_cycle();
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    set_load_use();
    for (int i = 0; i < 65540; i++) next_cycle();
    @(negedge clk);
    chk("cnt_stall_sat", cnt_stall, 16'hFFFF);
    next_cycle();
    @(negedge clk);
    chk("cnt_stall_sat_hold", cnt_stall, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline control unit for the 16-bit core: centralises load-use stall detection, branch flush, N-stage operand forwarding selection and a multi-cycle interrupt-entry sequencer. It sits beside the stage buffers, drives their hold/flush inputs and the fetch PC-select, and replaces the ad-hoc always-enabled buffers and two-stage-only forwarding of the current core. Hazard and forwarding outputs are combinational; interrupt sequencing and counters are registered.

## Interface
- NSTAGES, 5, pipeline depth; the block drives NSTAGES-1 stage buffers.
- REG_AW, 3, register-index width.
- FWD_STAGES, 2, number of later stages that can forward; index 0 is the nearest (EX/MEM).
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid, id_rs1_used, id_rs2_used  in  1 each  decode holds a real instruction / reads rs1 / reads rs2
- id_rs1, id_rs2  in  REG_AW  decode source registers
- ex_rd  in  REG_AW, ex_wb  in  1, ex_mem_read  in  1  instruction currently in execute
- ex_rs1, ex_rs2  in  REG_AW  execute source registers
- fwd_rd  in  FWD_STAGES*REG_AW, fwd_wb  in  FWD_STAGES  destinations/write-enables of later stages
- br_taken  in  1  execute resolved a taken branch/call/ret
- int_req  in  1  external interrupt pulse
- fwd_sel1, fwd_sel2  out  $clog2(FWD_STAGES+1)  0 = register file, k = forward from stage k-1
- hold_pc, hold_ifid  out  1  freeze PC and IF/ID buffer
- flush  out  NSTAGES-1  per-buffer bubble insert; bit 0 = IF/ID
- pc_sel  out  2  00 sequential, 01 branch target, 10 IVT, 11 hold
- push_pc  out  1  memory stage pushes current PC to stack
- int_ack  out  1  one-cycle acknowledge
- int_busy  out  1  sequencer not IDLE
- cnt_stall, cnt_flush, cnt_int  out  16 each  performance counters

## Operation
- Forwarding: fwd_selN = k+1 for the lowest k with fwd_wb[k] && fwd_rd[k] == ex_rsN; else 0. R0 is not special.
- Load-use: ex_mem_read && ex_wb && id_valid && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)) -> hold_pc=hold_ifid=1, pc_sel=11, flush[1]=1.
- Branch: br_taken -> pc_sel=01, flush[0]=flush[1]=1, no hold. Branch overrides load-use in the same cycle.
- Interrupt FSM (registered state): IDLE, DRAIN, PUSH, VECTOR.
  - IDLE: int_req or pending -> DRAIN; load drain counter with NSTAGES-2; clear pending.
  - DRAIN: hold_pc=1, flush[0]=1 each cycle; counter decrements to 0 -> PUSH. br_taken in DRAIN -> pc_sel=01 for that cycle (return address becomes target) and flush[1]=1; counter is not reloaded.
  - PUSH: push_pc=1 for one cycle, hold_pc=1, flush[0]=1 -> VECTOR.
  - VECTOR: pc_sel=10, int_ack=1, flush[0]=1 -> IDLE.
  - int_req when not IDLE sets the pending bit; serviced on the next IDLE cycle. There is no nesting.
- Priority: rst > interrupt FSM outputs (non-IDLE) > br_taken > load-use > normal. Load-use detection is masked while int_busy.

## Timing
- Hazard, flush, pc_sel and fwd_sel respond to inputs in the same cycle (combinational); counters and FSM update on the clk rising edge.
- Interrupt entry from int_req to pc_sel=10 takes NSTAGES+1 cycles (NSTAGES=5: 6 cycles).
- While rst is high:
  - flush is all ones; hold, push_pc, int_ack, fwd_sel are 0; pc_sel=00.
  - After the first edge: state IDLE, pending 0, counters 0.
- A reset asserted mid-sequence aborts it with no push or ack.
- int_busy=1 in every non-IDLE state.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - cnt_stall counts load-use stall cycles.
  - cnt_flush counts branch flushes.
  - cnt_int counts completed interrupt entries.
  - All counters are 16-bit, saturate at 0xFFFF and clear on rst.
- Macro undefined: counter registers are not built; the three ports are constant 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - pc_sel encodings PC_SEQ, PC_BR, PC_IVT, PC_HOLD.
  - FSM state typedef.
  - Flush bit-index constants FL_IFID, FL_IDEX, FL_EXMEM, FL_MEMWB.
- Sub-module pipe_fwd_sel: one priority-match instance per operand, parametrised by FWD_STAGES and REG_AW.

## Test plan
- ex_rs1=3, fwd_rd={3,3}, fwd_wb={1,1} -> fwd_sel1=1; same with fwd_wb[0]=0 -> fwd_sel1=2; no match -> 0.
- ex_mem_read=1, ex_wb=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> hold_pc=hold_ifid=1, flush=0b0010, pc_sel=11; with br_taken=1 added -> flush=0b0011, pc_sel=01, no hold.
- int_req pulse in IDLE (NSTAGES=5) -> DRAIN for 3 cycles, PUSH (push_pc=1), then VECTOR (pc_sel=10, int_ack=1) on cycle 6; back in IDLE on cycle 7.
- int_req during PUSH -> second full sequence begins the cycle after VECTOR.
- rst asserted in DRAIN -> next cycle IDLE, no push_pc/int_ack, flush all ones while rst is high.
- With PERF_EN defined: 3 load-use stalls + 2 branches + 1 interrupt -> cnt_stall=3, cnt_flush=2, cnt_int=1. Forcing cnt_stall to 0xFFFF -> stays at 0xFFFF on a further stall.
